bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the display-side binary-to-BCD/7-segment path.
- Accepts NDIG packed BCD digits (e.g. setpoint digits typed on the keypad) and returns the binary value.
- Uses reverse double-dabble: shift right one bit per cycle, then correct each digit by subtracting 3.
- Start/valid handshake; one conversion in flight at a time.

Parameters:
- NDIG, 3, number of BCD digits; digit 0 is units.
- BW, 10, binary result width; must satisfy 2^BW > 10^NDIG - 1 (static assertion).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  conversion request; sampled only in IDLE.
- bcd_i  in  4*NDIG  packed digits; [3:0] units, [7:4] tens, [11:8] hundreds.
- bin_o  out  BW  result; held until the next completed conversion.
- valid_o  out  1  one-cycle pulse when bin_o/err_o are updated.
- busy_o  out  1  high whenever state != IDLE.
- err_o  out  1  last conversion had a digit > 9; held with bin_o.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion): state=IDLE; bin_o=0, valid_o=0, busy_o=0, err_o=0; shift register and counter cleared. No valid_o pulse for an aborted conversion.
- States: IDLE, SHIFT, DONE.
- IDLE, start_i=1 at edge e0:
  - Load shift register SR = {bcd_i, BW'b0} (width 4*NDIG+BW); cnt=0.
  - If any digit > 9, go to DONE with error flag set.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - SR := SR >> 1 (zero fill at MSB).
  - Then each 4-bit digit field of the shifted SR: if >= 8, subtract 3 (no borrow across fields).
  - cnt++. After the BW-th shift (cnt == BW-1 at that edge), go to DONE.
  - bin_o := SR[BW-1:0] after the final shift.
  - err_o := 0.
- DONE, one cycle: valid_o=1, busy_o=1; next edge to IDLE.
- Error path: at edge e1 the block enters DONE with bin_o=0, err_o=1, valid_o=1 for one cycle.
- Latency: normal conversion has valid_o high during the cycle after edge eBW (e10 for defaults). Error conversion has valid_o high after e1. A new start is accepted on the edge after DONE, giving a throughput of one conversion per BW+1 cycles.
- start_i while busy_o=1 is ignored: not queued, not flagged.
- bcd_i is captured at e0 only; later changes do not affect the conversion in flight.
- Width rules:
  - The subtract-3 correction is applied to the shifted value; the unshifted value is never corrected.
  - Digit fields never exceed 4 bits after correction (values 8..15 map to 5..12; legal inputs never produce more than 12).
  - The binary field is never corrected.
- bin_o, err_o and valid_o are all registered outputs; no combinational path from the inputs.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - BCD_MAX_DIGIT=9.
  - BCD_ADJ_THRESH=8.
  - BCD_ADJ_VAL=3.
  - Function clog2-based minimum BW check.
- Sub-module bcd_digit_adj: 4-bit combinational corrector (in >= 8 ? in-3 : in), instantiated NDIG times via generate.
- The rest (FSM, counter, SR) stays in bcd2bin_seq.

Test Plan:
- Full sweep 000..999:
  - Stimulus: for each value, start_i with digits; wait for valid_o.
  - Response: bin_o equals the decimal value, err_o=0, valid_o high exactly 10 edges after the start edge, one cycle wide.
- Boundaries:
  - bcd_i=12'h255 gives bin_o=10'd255 (0x0FF).
  - 12'h999 gives 10'd999 (0x3E7).
  - 12'h000 gives 0.
  - 12'h100 gives 100.
- Invalid digits:
  - bcd_i=12'h1A3 gives valid_o at e1, err_o=1, bin_o=0.
  - A following start with 12'h042 gives bin_o=42, err_o=0.
- Start while busy:
  - Start 12'h123, then pulse start_i with 12'h456 at edge e4.
  - Response: exactly one valid_o, bin_o=123; busy_o high e0..DONE.
  - A back-to-back start on the edge leaving DONE is accepted.
- Mid-conversion reset and input change:
  - Change bcd_i at e3: result unaffected.
  - Assert rst_ni low between e5 and e6 of a 12'h789 conversion: all outputs 0 immediately (asynchronous), no valid_o.
  - After release, 12'h789 converts to 789.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_ADJ_THRESH = 8;
  localparam int BCD_ADJ_VAL    = 3;

  // True when a bw-bit result can hold every value of ndig BCD digits,
  // i.e. 2^bw > 10^ndig - 1.
  function automatic bit bw_ok(input int ndig, input int bw);
    int maxv;
    maxv = 1;
    for (int i = 0; i < ndig; i++) maxv = maxv * 10;
    return bw >= $clog2(maxv);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit corrector: a shifted digit field of 8 or more
// had a tens-borrow fold in from the digit above, so remove the excess 3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'(BCD_ADJ_THRESH)) ? d_i - 4'(BCD_ADJ_VAL) : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one right
// shift plus per-digit correction per cycle, BW cycles per conversion.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [4*NDIG-1:0] bcd_i,
  output logic [BW-1:0]   bin_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int SRW   = 4 * NDIG + BW;
  localparam int CNT_W = $clog2(BW + 1);

  if (!bw_ok(NDIG, BW)) begin : g_bw_check
    $error("bcd2bin_seq: BW too small to hold 10^NDIG-1");
  end

  state_e           state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bin_q, bin_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             bad_q, bad_d;

  logic [SRW-1:0]   sr_shift;
  logic [SRW-1:0]   sr_adj;
  logic             digit_bad;

  // Shift first, then correct each digit field; the binary field passes through.
  assign sr_shift = sr_q >> 1;
  assign sr_adj[BW-1:0] = sr_shift[BW-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (sr_shift[BW+4*g +: 4]),
      .d_o (sr_adj[BW+4*g +: 4])
    );
  end

  // Flag any input digit outside 0..9.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_i[4*i +: 4] > 4'(BCD_MAX_DIGIT)) digit_bad = 1'b1;
    end
  end

  // Next-state logic. DONE also accepts a start so a new conversion can
  // begin on the edge that leaves DONE (one conversion per BW+1 cycles).
  // A bad digit still spends one SHIFT cycle so the error result appears
  // on the first edge after the start edge.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    valid_d = 1'b0;
    bad_d   = bad_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          sr_d    = {bcd_i, {BW{1'b0}}};
          cnt_d   = '0;
          bad_d   = digit_bad;
          state_d = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bad_q) begin
          bin_d   = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          bad_d   = 1'b0;
          state_d = DONE;
        end else begin
          sr_d  = sr_adj;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BW - 1)) begin
            bin_d   = sr_adj[BW-1:0];
            err_d   = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any conversion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end

  assign bin_o   = bin_q;
  assign err_o   = err_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: decimal reference model, full sweep, random and
// directed scenarios.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        valid;
  logic        busy;
  logic        err;

  int n_vec;
  int n_err;

  bcd2bin_seq #(.NDIG(3), .BW(10)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bcd_i   (bcd),
    .bin_o   (bin),
    .valid_o (valid),
    .busy_o  (busy),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: digit-wise decimal interpretation.
  function automatic bit ref_bad(input logic [11:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
  endfunction

  function automatic int ref_val(input logic [11:0] v);
    if (ref_bad(v)) return 0;
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    r[3:0]  = 4'(n % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[11:8] = 4'((n / 100) % 10);
    return r;
  endfunction

  // One isolated conversion: check result, error flag, latency, pulse width.
  task automatic run_conv(input logic [11:0] v, input string tag);
    int lat;
    bit seen;
    int exp_lat;
    exp_lat = ref_bad(v) ? 1 : 10;
    @(negedge clk);
    start = 1'b1;
    bcd   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_bin"}, 32'(bin), 32'(ref_val(v)));
      chk({tag, "_err"}, 32'(err), 32'(ref_bad(v)));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(valid), 32'd0);
    end
  endtask

  initial begin
    logic [11:0] rv;
    int nval;
    int vbin;
    int vk1, vk2, vb1, vb2;

    n_vec = 0;
    n_err = 0;
    start = 1'b0;
    bcd   = '0;
    rst_n = 1'b0;

    // Reset state
    #12;
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boundaries
    run_conv(12'h255, "b255");
    run_conv(12'h999, "b999");
    run_conv(12'h000, "b000");
    run_conv(12'h100, "b100");

    // Invalid digit then recovery
    run_conv(12'h1A3, "inv1A3");
    run_conv(12'h042, "after_inv");

    // Full sweep
    for (int i = 0; i < 1000; i++) run_conv(to_bcd(i), "sweep");

    // Random, including out-of-range digits
    for (int i = 0; i < 150; i++) begin
      rv = 12'($urandom);
      if ($urandom_range(3) != 0) rv = to_bcd(int'($urandom_range(999)));
      run_conv(rv, "rand");
    end

    // Start while busy: second start at e4 ignored
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h123;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_e0", 32'(busy), 32'd1);
    nval = 0;
    vbin = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 4) begin
        start = 1'b1;
        bcd   = 12'h456;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k <= 10) chk("busy_hold", 32'(busy), 32'd1);
      if (valid) begin
        nval++;
        vbin = int'(bin);
      end
    end
    chk("busy_nvalid", 32'(nval), 32'd1);
    chk("busy_bin", 32'(vbin), 32'd123);
    chk("busy_idle", 32'(busy), 32'd0);

    // Back-to-back: second start presented while in DONE
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h321;
    @(posedge clk);
    #1;
    vk1 = 0; vk2 = 0; vb1 = 0; vb2 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 11) begin
        start = 1'b1;
        bcd   = 12'h654;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (valid) begin
        if (vk1 == 0) begin
          vk1 = k;
          vb1 = int'(bin);
        end else if (vk2 == 0) begin
          vk2 = k;
          vb2 = int'(bin);
        end
      end
    end
    chk("b2b_k1", 32'(vk1), 32'd10);
    chk("b2b_bin1", 32'(vb1), 32'd321);
    chk("b2b_k2", 32'(vk2), 32'd21);
    chk("b2b_bin2", 32'(vb2), 32'd654);

    // Input change at e3 does not disturb conversion
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h555;
    @(posedge clk);
    #1;
    start = 1'b0;
    vk1 = 0; vb1 = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) bcd = 12'h999;
      @(posedge clk);
      #1;
      if (valid && vk1 == 0) begin
        vk1 = k;
        vb1 = int'(bin);
      end
    end
    chk("chg_k", 32'(vk1), 32'd10);
    chk("chg_bin", 32'(vb1), 32'd555);

    // Asynchronous reset between e5 and e6 of a 789 conversion
    @(negedge clk);
    start = 1'b1;
    bcd   = 12'h789;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bin", 32'(bin), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (valid) nval++;
    end
    chk("arst_novalid", 32'(nval), 32'd0);
    run_conv(12'h789, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
